i2c_slave_regif: RTL and testbench

I2C target (slave) protocol engine that gives an external I2C master access to the 8-bit register file. It oversamples SCL/SDA on the system clock, decodes START/STOP, address, register pointer and data bytes, and issues single-cycle writes to the register file or fetches read data from it with auto-incrementing addressing. It sits between the board-level open-drain SDA/SCL pads and the register file write port (address, data, enable) and one register-file read port.

---
 rtl/i2c_slave_regif.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regif.sv
// I2C target bridging an external master to an 8-bit register file; auto-incrementing pointer.
// SCL/SDA are synchronised (2 flops) plus one edge-detect flop; outputs react the clk after a detected event.
module i2c_slave_regif #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         ADDR_W     = 8,
  parameter int         DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK
  } state_t;

  // [0],[1] synchroniser stages, [2] previous value for edge detection
  logic [2:0]        scl_sync_q, scl_sync_d;
  logic [2:0]        sda_sync_q, sda_sync_d;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              rw_q, rw_d;

  logic              scl_s, scl_p, sda_s, sda_p;
  logic              scl_rise, scl_fall, start_evt, stop_evt;
  logic              addr_match;

  assign scl_s     = scl_sync_q[1];
  assign scl_p     = scl_sync_q[2];
  assign sda_s     = sda_sync_q[1];
  assign sda_p     = sda_sync_q[2];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_evt = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_evt  = scl_s & scl_p & ~sda_p & sda_s;
  assign addr_match = (shift_q[DATA_W-1:1] == SLAVE_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl_in};
    sda_sync_d = {sda_sync_q[1:0], sda_in};
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    // the pointer advances the clk after a write strobe so the strobe sees the old value
    ptr_d      = we_q ? ptr_q + ADDR_W'(1) : ptr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;

    if (start_evt) begin
      state_d  = S_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop_evt) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
        end

        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shift_d = {shift_q[DATA_W-2:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (state_q == S_ADDR) begin
              if (addr_match) begin
                state_d  = S_ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
              end
            end else if (state_q == S_PTR) begin
              ptr_d    = ADDR_W'(shift_q);
              sda_oe_d = 1'b1;
              state_d  = S_PTR_ACK;
            end else begin
              wdata_d  = shift_q;
              we_d     = 1'b1;
              sda_oe_d = 1'b1;
              state_d  = S_WDATA_ACK;
            end
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              // first read byte goes out on the same fall that ends the ACK slot
              shift_d  = reg_rdata;
              ptr_d    = ptr_q + ADDR_W'(1);
              sda_oe_d = ~reg_rdata[DATA_W-1];
              state_d  = S_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_PTR;
            end
          end
        end

        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_WDATA;
          end
        end

        S_RDATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_oe_d = ~shift_q[DATA_W-1];
            end else if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = S_RDATA_ACK;
            end else begin
              shift_d  = {shift_q[DATA_W-2:0], 1'b0};
              sda_oe_d = ~shift_q[DATA_W-2];
            end
          end
        end

        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              // bit 7 of the next byte is driven on the following fall (cnt = 0)
              shift_d = reg_rdata;
              ptr_d   = ptr_q + ADDR_W'(1);
              cnt_d   = '0;
              state_d = S_RDATA;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end

        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench for i2c_slave_regif: bit-level I2C master, combinational register file, transaction-level model.
module tb_i2c_slave_regif;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b0;
  logic       scl_in, sda_in;
  logic       sda_oe, reg_we, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  logic [7:0]  mem     [256];
  logic [7:0]  exp_mem [256];
  logic [7:0]  exp_ptr;
  logic [15:0] wq[$];
  logic [15:0] exp_wq[$];
  logic [7:0]  data_q[$];
  int          checks = 0;
  int          errors = 0;

  assign scl_in    = scl_m;
  assign sda_in    = sda_m & ~sda_oe;
  assign reg_rdata = mem[reg_addr];

  always #5 clk = ~clk;

  i2c_slave_regif #(.SLAVE_ADDR(7'h50), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata),
    .busy(busy)
  );

  // register file: one entry per strobed clk, so a stretched strobe shows up as an extra write
  always @(negedge clk) begin
    if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
      wq.push_back({reg_addr, reg_wdata});
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b; tick(Q); scl_m = 1'b1; tick(Q/2); r = sda_in; tick(Q/2); scl_m = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  // reference model: a byte array and a wrapping pointer
  task automatic m_write(input logic [7:0] d);
    exp_wq.push_back({exp_ptr, d});
    exp_mem[exp_ptr] = d;
    exp_ptr = exp_ptr + 8'd1;
  endtask

  task automatic m_read(output logic [7:0] d);
    d = exp_mem[exp_ptr];
    exp_ptr = exp_ptr + 8'd1;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, wq.size(), exp_wq.size());
    while (wq.size() > 0 && exp_wq.size() > 0) chk({tag, "_wr"}, wq.pop_front(), exp_wq.pop_front());
    wq.delete();
    exp_wq.delete();
  endtask

  task automatic do_write(input string tag, input logic [7:0] ptr);
    logic ack;
    i2c_start();
    wr_byte(8'hA0, ack); chk({tag, "_aack"}, ack, 1'b1);
    chk({tag, "_busy"}, busy, 1'b1);
    wr_byte(ptr, ack);   chk({tag, "_pack"}, ack, 1'b1);
    exp_ptr = ptr;
    foreach (data_q[i]) begin
      wr_byte(data_q[i], ack); chk({tag, "_dack"}, ack, 1'b1);
      m_write(data_q[i]);
    end
    i2c_stop();
    tick(4);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_ptr"}, reg_addr, exp_ptr);
    check_writes(tag);
  endtask

  task automatic read_bytes(input string tag, input int n);
    logic [7:0] d, e;
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, d);
      m_read(e);
      chk({tag, "_data"}, d, e);
    end
    tick(4);
    chk({tag, "_oe_nack"}, sda_oe, 1'b0);
    chk({tag, "_busy_nack"}, busy, 1'b0);
    i2c_stop();
    tick(4);
    chk({tag, "_ptr"}, reg_addr, exp_ptr);
    check_writes(tag);
  endtask

  task automatic do_read(input string tag, input logic [7:0] ptr, input int n);
    logic ack;
    i2c_start();
    wr_byte(8'hA0, ack); chk({tag, "_aack"}, ack, 1'b1);
    wr_byte(ptr, ack);   chk({tag, "_pack"}, ack, 1'b1);
    exp_ptr = ptr;
    i2c_start();
    wr_byte(8'hA1, ack); chk({tag, "_rack"}, ack, 1'b1);
    read_bytes(tag, n);
  endtask

  task automatic cur_read(input string tag, input int n);
    logic ack;
    i2c_start();
    wr_byte(8'hA1, ack); chk({tag, "_rack"}, ack, 1'b1);
    read_bytes(tag, n);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] p;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    exp_ptr = 8'h00;

    // reset held with SDA pulled low by the master
    tick(2);
    chk("rst_oe", sda_oe, 1'b0);
    chk("rst_we", reg_we, 1'b0);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_busy", busy, 1'b0);
    sda_m = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(Q);

    data_q = {8'h55, 8'hAA};
    do_write("wr", 8'h10);
    chk("wr_ptr12", reg_addr, 8'h12);

    do_read("rd", 8'h10, 2);

    data_q = {8'h01, 8'h02};
    do_write("wrap", 8'hFF);
    chk("wrap_ff", mem[8'hFF], 8'h01);
    chk("wrap_00", mem[8'h00], 8'h02);

    // address 0x51: target must stay silent until the next START
    i2c_start();
    wr_byte(8'hA2, ack); chk("mis_ack", ack, 1'b0);
    chk("mis_busy", busy, 1'b0);
    wr_byte(8'h20, ack); chk("mis_ack2", ack, 1'b0);
    wr_byte(8'h77, ack); chk("mis_ack3", ack, 1'b0);
    i2c_stop();
    tick(4);
    chk("mis_ptr", reg_addr, exp_ptr);
    check_writes("mis");

    // STOP after 4 data bits: partial byte discarded
    p = 8'($urandom);
    i2c_start();
    wr_byte(8'hA0, ack); chk("abt_aack", ack, 1'b1);
    wr_byte(p, ack);     chk("abt_pack", ack, 1'b1);
    exp_ptr = p;
    for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), r);
    i2c_stop();
    tick(4);
    chk("abt_busy", busy, 1'b0);
    chk("abt_ptr", reg_addr, exp_ptr);
    check_writes("abt");
    cur_read("abt_cur", 1);

    for (int k = 0; k < 6; k++) begin
      data_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) data_q.push_back(8'($urandom));
      do_write("rnd_wr", 8'($urandom));
      do_read("rnd_rd", 8'($urandom), int'($urandom_range(1, 3)));
      cur_read("rnd_cur", int'($urandom_range(1, 2)));
    end

    // reset in the middle of a read byte whose bits are all driven low by the target
    p = 8'($urandom);
    data_q = {8'h00};
    do_write("mrst_wr", p);
    i2c_start();
    wr_byte(8'hA0, ack); chk("mrst_aack", ack, 1'b1);
    wr_byte(p, ack);     chk("mrst_pack", ack, 1'b1);
    i2c_start();
    wr_byte(8'hA1, ack); chk("mrst_rack", ack, 1'b1);
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, r);
    tick(2);
    chk("mrst_pre_oe", sda_oe, 1'b1);
    reset = 1'b1;
    tick(1);
    chk("mrst_oe", sda_oe, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_addr", reg_addr, 8'h00);
    chk("mrst_we", reg_we, 1'b0);
    scl_m = 1'b1; tick(2);
    sda_m = 1'b1; tick(2);
    reset = 1'b0;
    tick(Q);
    wq.delete();
    exp_ptr = 8'h00;
    cur_read("post_rst", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
